// File: rtl/debug_display_pkg.sv
// Shared constants and helpers for the debug seven-segment display path.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package debug_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stable-count debouncer producing a one-cycle rise pulse.
// A second input (aux) shares the synchroniser only and is returned synchronised.
module button_debouncer
  import debug_display_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic aux,
  output logic aux_sync,
  output logic rise
);

  localparam int CNT_W = sel_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       btn_ff;
  logic [1:0]       aux_ff;
  logic [CNT_W-1:0] cnt;
  logic             level;

  // NOTE: non-blocking assignments make every flop sample pre-edge values,
  // which is what keeps the two synchroniser stages from collapsing into one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_ff <= '0;
      aux_ff <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      btn_ff <= {btn_ff[0], btn};
      aux_ff <= {aux_ff[0], aux};
      rise   <= 1'b0;
      if (btn_ff[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= btn_ff[1];
        cnt   <= '0;
        rise  <= btn_ff[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign aux_sync = aux_ff[1];

endmodule

// File: rtl/debug_display_ctrl.sv
// Channel-selectable, freezable hex debug display with multiplexed seven-segment scan.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module debug_display_ctrl
  import debug_display_pkg::*;
#(
  parameter  int NUM_CH       = 4,
  parameter  int DATA_W       = 32,
  parameter  int SCAN_DIV     = 50000,
  parameter  int DEBOUNCE_CYC = 16,
  localparam int NUM_DIGITS   = DATA_W / 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH*DATA_W-1:0]       ch_data,
  input  logic                           btn_next,
  input  logic                           freeze,
  output logic [6:0]                     seg_out,
  output logic [NUM_DIGITS-1:0]          an_out,
  output logic [sel_width(NUM_CH)-1:0]   ch_sel_out,
  output logic                           frozen
);

  localparam int CH_SEL_W = sel_width(NUM_CH);
  localparam int PRE_W    = sel_width(SCAN_DIV);
  localparam int DIG_W    = sel_width(NUM_DIGITS);
  localparam logic [CH_SEL_W-1:0] CH_LAST  = CH_SEL_W'(NUM_CH - 1);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0]    DIG_LAST = DIG_W'(NUM_DIGITS - 1);

  logic              step;
  logic              freeze_sync;
  logic [DATA_W-1:0] live_word;
  logic [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0] disp_word;
  logic [PRE_W-1:0]  presc;
  logic [DIG_W-1:0]  digit;
  logic [3:0]        nibble;
  logic [6:0]        seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn_next),
    .aux      (freeze),
    .aux_sync (freeze_sync),
    .rise     (step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_sel_out <= '0;
    end else if (step) begin
      ch_sel_out <= (ch_sel_out == CH_LAST) ? '0 : ch_sel_out + 1'b1;
    end
  end

  assign live_word = ch_data[ch_sel_out*DATA_W +: DATA_W];

  // frozen doubles as the previous freeze level, so a rising edge is freeze_sync && !frozen.
  // NOTE: hold_reg is a single data register, so it is reset like the rest; no X can reach the segments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frozen   <= 1'b0;
      hold_reg <= '0;
    end else begin
      frozen <= freeze_sync;
      if (freeze_sync && !frozen) hold_reg <= live_word;
    end
  end

  assign disp_word = frozen ? hold_reg : live_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      digit <= '0;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
      digit <= (digit == DIG_LAST) ? '0 : digit + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    nibble   = disp_word[4*digit +: 4];
    seg_next = hex_to_seg(nibble);
    an_next  = ~(NUM_DIGITS'(1) << digit);
`ifdef LEADING_ZERO_BLANK_EN
    if (digit != '0 && (disp_word >> (4*digit)) == '0) seg_next = SEG_BLANK;
`else
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_out <= SEG_BLANK;
      an_out  <= '1;
    end else begin
      seg_out <= seg_next;
      an_out  <= an_next;
    end
  end

endmodule

// File: tb/tb_debug_display_ctrl.sv
// Randomised self-checking bench for debug_display_ctrl against a digit/scan model.
// Build with or without LEADING_ZERO_BLANK_EN; the model follows the same macro.
module tb_debug_display_ctrl;

  localparam int NUM_CH       = 4;
  localparam int DATA_W       = 32;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CYC = 4;
  localparam int ND           = DATA_W / 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     btn_next;
  logic                     freeze;
  logic [6:0]               seg_out;
  logic [ND-1:0]            an_out;
  logic [1:0]               ch_sel_out;
  logic                     frozen;

  int tests_run    = 0;
  int tests_failed = 0;
  int edges;
  int m_sel;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  debug_display_ctrl #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) dut (
    .clk(clk), .reset(reset), .ch_data(ch_data), .btn_next(btn_next), .freeze(freeze),
    .seg_out(seg_out), .an_out(an_out), .ch_sel_out(ch_sel_out), .frozen(frozen)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; output after edge k shows the digit lit before edge k.
  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  function automatic int digit_of(input int k);
    return ((k - 1) / SCAN_DIV) % ND;
  endfunction

  function automatic logic [ND-1:0] exp_an(input int k);
    logic [ND-1:0] one = 1;
    return ~(one << digit_of(k));
  endfunction

  function automatic logic [6:0] exp_seg(input logic [31:0] w, input int d);
    logic [31:0] upper;
    upper = w >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && upper == 0) return 7'h7F;
`endif
    return hex_tbl[upper[3:0]];
  endfunction

  function automatic logic [31:0] chan(input int k);
    return ch_data[k*DATA_W +: DATA_W];
  endfunction

  task automatic press();
    int nb;
    nb = $urandom_range(0, 3);
    for (int j = 0; j < nb; j++) begin
      btn_next = 1'b1; @(negedge clk);
      btn_next = 1'b0; @(negedge clk);
    end
    btn_next = 1'b1;
    repeat ($urandom_range(7, 12)) @(negedge clk);
    btn_next = 1'b0;
    repeat ($urandom_range(8, 12)) @(negedge clk);
    m_sel = (m_sel + 1) % NUM_CH;
  endtask

  task automatic test_reset();
    reset = 1'b1; freeze = 1'b0; btn_next = 1'b0; m_sel = 0;
    for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = $urandom;
    ch_data[31:0] = 32'h1234ABCD;
    repeat (3) @(negedge clk);
    tests_run += 4;
    if (an_out !== 8'hFF) begin tests_failed++; $display("FAIL rst_an got %h want ff", an_out); end
    if (seg_out !== 7'h7F) begin tests_failed++; $display("FAIL rst_seg got %h want 7f", seg_out); end
    if (ch_sel_out !== 2'd0) begin tests_failed++; $display("FAIL rst_sel got %0d want 0", ch_sel_out); end
    if (frozen !== 1'b0) begin tests_failed++; $display("FAIL rst_frozen got %b want 0", frozen); end
    reset = 1'b0;
    @(negedge clk);
    tests_run += 2;
    if (an_out !== 8'hFE) begin tests_failed++; $display("FAIL first_an got %h want fe", an_out); end
    if (seg_out !== 7'h21) begin tests_failed++; $display("FAIL first_seg got %h want 21", seg_out); end
    for (int i = 0; i < ND * SCAN_DIV; i++) begin
      @(negedge clk);
      tests_run++;
      if (an_out !== exp_an(edges) || seg_out !== exp_seg(32'h1234ABCD, digit_of(edges))) begin
        tests_failed++;
        $display("FAIL scan_1234abcd edge %0d got an=%h seg=%h want an=%h seg=%h", edges,
                 an_out, seg_out, exp_an(edges), exp_seg(32'h1234ABCD, digit_of(edges)));
      end
    end
  endtask

  task automatic test_scan_random();
    logic [31:0] w;
    for (int t = 0; t < 6; t++) begin
      case (t)
        0: w = 32'h0;
        1: w = 32'hFFFFFFFF;
        default: w = $urandom >> (4 * $urandom_range(0, 7));
      endcase
      ch_data[31:0] = w;
      @(negedge clk);
      for (int i = 0; i < ND * SCAN_DIV; i++) begin
        @(negedge clk);
        tests_run++;
        if (an_out !== exp_an(edges) || seg_out !== exp_seg(w, digit_of(edges))) begin
          tests_failed++;
          $display("FAIL scan_rand w=%h edge %0d got an=%h seg=%h want an=%h seg=%h", w, edges,
                   an_out, seg_out, exp_an(edges), exp_seg(w, digit_of(edges)));
        end
      end
    end
  endtask

  task automatic test_debounce();
    for (int i = 0; i < 10; i++) begin
      btn_next = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    tests_run++;
    if (ch_sel_out !== 2'(m_sel)) begin
      tests_failed++; $display("FAIL bounce_no_step got %0d want %0d", ch_sel_out, m_sel);
    end
    btn_next = 1'b1; repeat (10) @(negedge clk);
    btn_next = 1'b0; repeat (10) @(negedge clk);
    m_sel = (m_sel + 1) % NUM_CH;
    tests_run++;
    if (ch_sel_out !== 2'(m_sel)) begin
      tests_failed++; $display("FAIL bounce_one_step got %0d want %0d", ch_sel_out, m_sel);
    end
    while (m_sel != 3) press();
    tests_run++;
    if (ch_sel_out !== 2'd3) begin
      tests_failed++; $display("FAIL press_to_3 got %0d want 3", ch_sel_out);
    end
    for (int p = 0; p < 4; p++) begin
      press();
      tests_run++;
      if (ch_sel_out !== 2'(m_sel)) begin
        tests_failed++; $display("FAIL press_wrap%0d got %0d want %0d", p, ch_sel_out, m_sel);
      end
    end
  endtask

  task automatic test_freeze();
    int n;
    logic [31:0] live;
    while (m_sel != 1) press();
    ch_data[1*DATA_W +: DATA_W] = 32'hDEADBEEF;
    ch_data[2*DATA_W +: DATA_W] = 32'h13579BDF ^ ($urandom & 32'h0F0F0F0F);
    @(negedge clk);
    freeze = 1'b1;
    n = 0;
    while (frozen !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    tests_run++;
    if (frozen !== 1'b1) begin tests_failed++; $display("FAIL freeze_rise got %b want 1", frozen); end
    ch_data[1*DATA_W +: DATA_W] = 32'h0;
    for (int i = 0; i < ND * SCAN_DIV; i++) begin
      @(negedge clk);
      tests_run++;
      if (an_out !== exp_an(edges) || seg_out !== exp_seg(32'hDEADBEEF, digit_of(edges))) begin
        tests_failed++;
        $display("FAIL frozen_scan edge %0d got an=%h seg=%h want an=%h seg=%h", edges,
                 an_out, seg_out, exp_an(edges), exp_seg(32'hDEADBEEF, digit_of(edges)));
      end
    end
    press();
    tests_run++;
    if (ch_sel_out !== 2'(m_sel)) begin
      tests_failed++; $display("FAIL frozen_step got %0d want %0d", ch_sel_out, m_sel);
    end
    for (int i = 0; i < ND * SCAN_DIV; i++) begin
      @(negedge clk);
      tests_run++;
      if (frozen !== 1'b1 || seg_out !== exp_seg(32'hDEADBEEF, digit_of(edges))) begin
        tests_failed++;
        $display("FAIL frozen_after_step edge %0d got seg=%h frozen=%b want seg=%h frozen=1",
                 edges, seg_out, frozen, exp_seg(32'hDEADBEEF, digit_of(edges)));
      end
    end
    freeze = 1'b0;
    n = 0;
    while (frozen !== 1'b0 && n < 3) begin @(negedge clk); n++; end
    tests_run++;
    if (frozen !== 1'b0) begin tests_failed++; $display("FAIL freeze_fall got %b want 0", frozen); end
    live = chan(m_sel);
    for (int i = 0; i < ND * SCAN_DIV; i++) begin
      @(negedge clk);
      tests_run++;
      if (an_out !== exp_an(edges) || seg_out !== exp_seg(live, digit_of(edges))) begin
        tests_failed++;
        $display("FAIL live_scan w=%h edge %0d got an=%h seg=%h want an=%h seg=%h", live, edges,
                 an_out, seg_out, exp_an(edges), exp_seg(live, digit_of(edges)));
      end
    end
  endtask

  task automatic test_reset_midscan();
    int n;
    freeze = 1'b1;
    n = 0;
    while (frozen !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    n = 0;
    while (an_out !== 8'hDF && n < 40) begin @(negedge clk); n++; end
    tests_run++;
    if (an_out !== 8'hDF || frozen !== 1'b1) begin
      tests_failed++; $display("FAIL reach_digit5 got an=%h frozen=%b want an=df frozen=1", an_out, frozen);
    end
    #2 reset = 1'b1;
    freeze = 1'b0;
    #1;
    tests_run += 4;
    if (an_out !== 8'hFF) begin tests_failed++; $display("FAIL mid_rst_an got %h want ff", an_out); end
    if (seg_out !== 7'h7F) begin tests_failed++; $display("FAIL mid_rst_seg got %h want 7f", seg_out); end
    if (ch_sel_out !== 2'd0) begin tests_failed++; $display("FAIL mid_rst_sel got %0d want 0", ch_sel_out); end
    if (frozen !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_frozen got %b want 0", frozen); end
    @(negedge clk);
    reset = 1'b0;
    m_sel = 0;
    @(negedge clk);
    tests_run++;
    if (an_out !== 8'hFE) begin tests_failed++; $display("FAIL post_rst_an got %h want fe", an_out); end
  endtask

  task automatic test_blank();
    ch_data[31:0] = 32'h00000A05;
    @(negedge clk);
    for (int i = 0; i < ND * SCAN_DIV; i++) begin
      @(negedge clk);
      tests_run++;
      if (an_out !== exp_an(edges) || seg_out !== exp_seg(32'h00000A05, digit_of(edges))) begin
        tests_failed++;
        $display("FAIL blank_scan edge %0d got an=%h seg=%h want an=%h seg=%h", edges,
                 an_out, seg_out, exp_an(edges), exp_seg(32'h00000A05, digit_of(edges)));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_scan_random();
    test_debounce();
    test_freeze();
    test_reset_midscan();
    test_blank();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
